// File: rtl/mult_pkg.sv
// Shared constants, state encoding and payload types for the multiplier job sequencer.
package mult_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned CNT_W  = 2;

  localparam logic [CNT_W-1:0] CNT_LSB  = 2'b00;
  localparam logic [CNT_W-1:0] CNT_MID0 = 2'b01;
  localparam logic [CNT_W-1:0] CNT_MID1 = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MSB  = 2'b11;

  localparam int unsigned NOMINAL_LATENCY = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_RUN       = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_HOLD      = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_pair_t;

  // Phase sequence seen by the controller; sticks at the last phase.
  function automatic logic [CNT_W-1:0] next_phase(input logic [CNT_W-1:0] cur);
    case (cur)
      CNT_LSB:  return CNT_MID0;
      CNT_MID0: return CNT_MID1;
      default:  return CNT_MSB;
    endcase
  endfunction

endpackage

// File: rtl/mult_job_sequencer_if.sv
// Operand stream, datapath/controller handshake and result stream of the job sequencer.
interface mult_job_sequencer_if;
  import mult_pkg::*;

  logic              op_valid;
  logic              op_ready;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic [OP_W-1:0]   dataa;
  logic [OP_W-1:0]   datab;
  logic              start;
  logic [CNT_W-1:0]  count;
  logic              done;
  logic [PROD_W-1:0] product;
  logic              res_valid;
  logic              res_ready;
  logic [PROD_W-1:0] res_product;
  logic              res_err;

  modport master (
    input  op_valid, op_a, op_b, done, product, res_ready,
    output op_ready, dataa, datab, start, count, res_valid, res_product, res_err
  );

  modport slave (
    output op_valid, op_a, op_b, done, product, res_ready,
    input  op_ready, dataa, datab, start, count, res_valid, res_product, res_err
  );

endinterface

// File: rtl/mult_operand_fifo.sv
// Small synchronous FIFO holding queued operand pairs; DEPTH must be a power of two.
module mult_operand_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_a,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full queue is legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mult_job_sequencer.sv
// Queues operand pairs, sequences start/count for the multiplier controller,
// retries stalled jobs and returns products on a valid/ready result stream.
module mult_job_sequencer
  import mult_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TIMEOUT   = 8,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                 clk,
  input  logic                 reset_a,
  mult_job_sequencer_if.master bus
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int unsigned PAY_W = $bits(op_pair_t);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TIMEOUT);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  seq_state_t        state_q, state_d;
  logic              start_q, start_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [OP_W-1:0]   dataa_q, dataa_d;
  logic [OP_W-1:0]   datab_q, datab_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic              res_valid_q, res_valid_d;
  logic              res_err_q, res_err_d;
  logic [PROD_W-1:0] res_product_q, res_product_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  op_pair_t          fifo_wdata;
  op_pair_t          fifo_rdata;
  logic [PAY_W-1:0]  fifo_rdata_raw;
  logic              job_end;
  logic              job_fail;

  assign fifo_push  = bus.op_valid && !fifo_full;
  assign fifo_wdata = '{a: bus.op_a, b: bus.op_b};
  assign fifo_rdata = op_pair_t'(fifo_rdata_raw);

  mult_operand_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAY_W)
  ) u_fifo (
    .clk     (clk),
    .reset_a (reset_a),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state, counters and result register.
  always_comb begin
    state_d       = state_q;
    start_d       = 1'b0;
    count_d       = count_q;
    dataa_d       = dataa_q;
    datab_d       = datab_q;
    tmo_d         = tmo_q;
    retry_d       = retry_q;
    res_valid_d   = res_valid_q && !bus.res_ready;
    res_err_d     = res_err_q;
    res_product_d = res_product_q;
    fifo_pop      = 1'b0;
    job_end       = 1'b0;
    job_fail      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && (!res_valid_q || bus.res_ready)) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // A re-issue keeps the operands already on the datapath.
        if (retry_q == '0) begin
          fifo_pop = 1'b1;
          dataa_d  = fifo_rdata.a;
          datab_d  = fifo_rdata.b;
        end
        tmo_d   = TMO_W'(1);
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (tmo_q != TMO_SAT) tmo_d = tmo_q + TMO_W'(1);
        count_d = next_phase(count_q);
        if (bus.done)                 job_end = 1'b1;
        else if (count_q == CNT_MSB)  state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tmo_q != TMO_SAT) tmo_d = tmo_q + TMO_W'(1);
        if (bus.done) begin
          job_end = 1'b1;
        end else if (tmo_q >= TMO_LAST) begin
          if (retry_q >= RTY_MAX) begin
            job_fail = 1'b1;
          end else begin
            retry_d = retry_q + RTY_W'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_HOLD: begin
        if (!res_valid_q || bus.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Post a result; chain straight into the next job only if the consumer is ready.
    if (job_end || job_fail) begin
      res_valid_d   = 1'b1;
      res_err_d     = job_fail;
      res_product_d = job_end ? bus.product : '0;
      retry_d       = '0;
      if (!bus.res_ready)   state_d = ST_HOLD;
      else if (!fifo_empty) state_d = ST_ISSUE;
      else                  state_d = ST_IDLE;
    end

    if (state_d == ST_ISSUE) begin
      start_d = 1'b1;
      count_d = CNT_LSB;
    end
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q       <= ST_IDLE;
      start_q       <= 1'b0;
      count_q       <= CNT_LSB;
      dataa_q       <= '0;
      datab_q       <= '0;
      tmo_q         <= '0;
      retry_q       <= '0;
      res_valid_q   <= 1'b0;
      res_err_q     <= 1'b0;
      res_product_q <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      count_q       <= count_d;
      dataa_q       <= dataa_d;
      datab_q       <= datab_d;
      tmo_q         <= tmo_d;
      retry_q       <= retry_d;
      res_valid_q   <= res_valid_d;
      res_err_q     <= res_err_d;
      res_product_q <= res_product_d;
    end
  end

  assign bus.op_ready    = !fifo_full;
  assign bus.dataa       = dataa_q;
  assign bus.datab       = datab_q;
  assign bus.start       = start_q;
  assign bus.count       = count_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_product = res_product_q;
  assign bus.res_err     = res_err_q;

endmodule
